// File: rtl/timer_mode_ctrl_if.sv
// timer_mode_ctrl_if: signal bundle between the kitchen-timer mode sequencer and its neighbours
//   master: drives bt_start, bt_prog, bt_inc (debounced levels) and done (terminal count)
//   slave : drives state, preset, load, digit_sel, blink (sequencer outputs)
interface timer_mode_ctrl_if;
  logic        bt_start;
  logic        bt_prog;
  logic        bt_inc;
  logic        done;
  logic [2:0]  state;
  logic [15:0] preset;
  logic        load;
  logic [3:0]  digit_sel;
  logic        blink;
  modport master (output bt_start, bt_prog, bt_inc, done, input state, preset, load, digit_sel, blink);
  modport slave  (input bt_start, bt_prog, bt_inc, done, output state, preset, load, digit_sel, blink);
endinterface

// File: rtl/timer_mode_ctrl.sv
// timer_mode_ctrl: IDLE/RUN/PAUSE/PROG/ALARM sequencer with BCD preset editing, load pulse and blink strobe
//   clk, rst_n (async, active-low)
//   bus.bt_start/bt_prog/bt_inc/done in; bus.state/preset/load/digit_sel/blink out (all registered)
//   Optional macro TIMER_MODE_CTRL_AUTOREPEAT_EN adds auto-repeat on a held bt_inc in PROG.
module timer_mode_ctrl #(
  parameter int          BLINK_DIV    = 12_500_000,
  parameter logic [15:0] PRESET_INIT  = 16'h0100,
  parameter int          REPEAT_DELAY = 25_000_000,
  parameter int          REPEAT_RATE  = 5_000_000
) (
  input logic              clk,
  input logic              rst_n,
  timer_mode_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2, PROG = 3'd3, ALARM = 3'd4} state_t;
  localparam int BW = $clog2(BLINK_DIV + 1);
  // The repeat counter reloads to REPEAT_DELAY-REPEAT_RATE+1 after each repeat, so the rate may not exceed the delay.
  if (BLINK_DIV < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_param
    $error("timer_mode_ctrl: bad BLINK_DIV/REPEAT_DELAY/REPEAT_RATE");
  end
  state_t        r_state, w_state_nxt;
  logic [15:0]   r_preset, w_preset_nxt;
  logic [3:0]    r_sel, w_sel_nxt;
  logic          r_load, w_load_nxt;
  logic          r_blink;
  logic [BW-1:0] r_blink_cnt;
  logic          r_start_q, r_prog_q, r_inc_q;
  logic          w_start_re, w_prog_re, w_inc_re, w_inc_req;
  assign w_start_re = bus.bt_start & ~r_start_q;
  assign w_prog_re  = bus.bt_prog & ~r_prog_q;
  assign w_inc_re   = bus.bt_inc & ~r_inc_q;
`ifdef TIMER_MODE_CTRL_AUTOREPEAT_EN
  logic [31:0] r_rep_cnt;
  logic        w_rep;
  // r_rep_cnt counts cycles since the press; after the first repeat it reloads so the next one lands REPEAT_RATE later.
  assign w_rep = r_state == PROG && bus.bt_inc && r_inc_q && r_rep_cnt == 32'(REPEAT_DELAY);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rep_cnt <= '0;
    else if (r_state != PROG || !bus.bt_inc) r_rep_cnt <= '0;
    else if (w_inc_re) r_rep_cnt <= 32'd1;
    else r_rep_cnt <= w_rep ? 32'(REPEAT_DELAY - REPEAT_RATE + 1) : r_rep_cnt + 32'd1;
  assign w_inc_req = w_inc_re | w_rep;
`else
  assign w_inc_req = w_inc_re;
`endif
  always_comb begin
    w_state_nxt  = r_state;
    w_preset_nxt = r_preset;
    w_sel_nxt    = r_sel;
    w_load_nxt   = 1'b0;
    case (r_state)
      IDLE:
        if (w_start_re) w_state_nxt = RUN;
        else if (w_prog_re) begin
          w_state_nxt = PROG;
          w_sel_nxt   = 4'b1000;
        end
      RUN:
        if (bus.done) w_state_nxt = ALARM;
        else if (w_start_re) w_state_nxt = PAUSE;
      PAUSE:
        if (w_start_re) w_state_nxt = RUN;
        else if (w_prog_re) begin
          w_state_nxt = IDLE;
          w_load_nxt  = 1'b1;
        end
      PROG:
        if (w_start_re || (w_prog_re && r_sel[0])) begin
          w_state_nxt = IDLE;
          w_sel_nxt   = 4'b0000;
          w_load_nxt  = 1'b1;
        end else if (w_prog_re) w_sel_nxt = r_sel >> 1;
        else if (w_inc_req)
          for (int i = 0; i < 4; i++)
            if (r_sel[i]) w_preset_nxt[4*i +: 4] = (r_preset[4*i +: 4] == 4'd9) ? 4'd0 : r_preset[4*i +: 4] + 4'd1;
      ALARM:
        if (w_start_re || w_prog_re) begin
          w_state_nxt = IDLE;
          w_load_nxt  = 1'b1;
        end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = 4'b0000;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_preset  <= PRESET_INIT;
      r_sel     <= 4'b0000;
      r_load    <= 1'b0;
      r_start_q <= 1'b0;
      r_prog_q  <= 1'b0;
      r_inc_q   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_preset  <= w_preset_nxt;
      r_sel     <= w_sel_nxt;
      r_load    <= w_load_nxt;
      r_start_q <= bus.bt_start;
      r_prog_q  <= bus.bt_prog;
      r_inc_q   <= bus.bt_inc;
    end
  // Blink restarts from a known phase on every state change and idles low outside PROG/ALARM.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_state_nxt != r_state || !(r_state == PROG || r_state == ALARM)) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else r_blink_cnt <= r_blink_cnt + BW'(1);
  assign bus.state     = r_state;
  assign bus.preset    = r_preset;
  assign bus.load      = r_load;
  assign bus.digit_sel = r_sel;
  assign bus.blink     = r_blink;
endmodule

// File: tb/tb_timer_mode_ctrl.sv
// tb_timer_mode_ctrl: directed self-checking bench for timer_mode_ctrl
module tb_timer_mode_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
`ifdef TIMER_MODE_CTRL_AUTOREPEAT_EN
  localparam logic [3:0] EXP_REP = 4'd5;
`else
  localparam logic [3:0] EXP_REP = 4'd1;
`endif
  timer_mode_ctrl_if bus ();
  timer_mode_ctrl #(
    .BLINK_DIV   (4),
    .PRESET_INIT (16'h0100),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_prog();
    bus.bt_prog = 1'b1;
    tick();
    bus.bt_prog = 1'b0;
    tick();
  endtask
  task automatic pulse_inc();
    bus.bt_inc = 1'b1;
    tick();
    bus.bt_inc = 1'b0;
    tick();
  endtask
  task automatic pulse_start();
    bus.bt_start = 1'b1;
    tick();
    bus.bt_start = 1'b0;
    tick();
  endtask
  initial begin
    bus.bt_start = 1'b0;
    bus.bt_prog  = 1'b0;
    bus.bt_inc   = 1'b0;
    bus.done     = 1'b0;
    tick();
    tick();
    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_preset", bus.preset, 16'h0100);
    chk("rst_load", 16'(bus.load), 16'd0);
    chk("rst_sel", 16'(bus.digit_sel), 16'd0);
    chk("rst_blink", 16'(bus.blink), 16'd0);
    rst_n = 1'b1;
    tick();
    bus.bt_start = 1'b1;
    tick();
    chk("idle_to_run", 16'(bus.state), 16'd1);
    bus.bt_start = 1'b0;
    tick();
    chk("run_hold", 16'(bus.state), 16'd1);
    pulse_start();
    chk("run_to_pause", 16'(bus.state), 16'd2);
    pulse_start();
    chk("pause_to_run", 16'(bus.state), 16'd1);
    bus.done = 1'b1;
    tick();
    chk("run_to_alarm", 16'(bus.state), 16'd4);
    chk("alarm_blink0", 16'(bus.blink), 16'd0);
    bus.done = 1'b0;
    tick();
    tick();
    tick();
    chk("alarm_blink_k3", 16'(bus.blink), 16'd0);
    tick();
    chk("alarm_blink_k4", 16'(bus.blink), 16'd1);
    tick();
    tick();
    tick();
    chk("alarm_blink_k7", 16'(bus.blink), 16'd1);
    tick();
    chk("alarm_blink_k8", 16'(bus.blink), 16'd0);
    bus.bt_prog = 1'b1;
    tick();
    chk("alarm_exit_state", 16'(bus.state), 16'd0);
    chk("alarm_exit_load", 16'(bus.load), 16'd1);
    bus.bt_prog = 1'b0;
    tick();
    chk("alarm_load_once", 16'(bus.load), 16'd0);
    bus.bt_prog = 1'b1;
    tick();
    chk("prog_enter", 16'(bus.state), 16'd3);
    chk("prog_sel_msn", 16'(bus.digit_sel), 16'h8);
    bus.bt_prog = 1'b0;
    tick();
    pulse_prog();
    pulse_prog();
    pulse_prog();
    chk("prog_sel_lsn", 16'(bus.digit_sel), 16'h1);
    repeat (8) pulse_inc();
    chk("inc_to_8", bus.preset, 16'h0108);
    pulse_inc();
    chk("inc_to_9", bus.preset, 16'h0109);
    pulse_inc();
    chk("inc_wrap_0", bus.preset, 16'h0100);
    pulse_inc();
    chk("inc_to_1", bus.preset, 16'h0101);
    bus.bt_prog = 1'b1;
    tick();
    chk("lsn_prog_idle", 16'(bus.state), 16'd0);
    chk("lsn_prog_load", 16'(bus.load), 16'd1);
    bus.bt_prog = 1'b0;
    tick();
    pulse_prog();
    chk("walk_sel_1000", 16'(bus.digit_sel), 16'h8);
    pulse_prog();
    chk("walk_sel_0100", 16'(bus.digit_sel), 16'h4);
    pulse_prog();
    chk("walk_sel_0010", 16'(bus.digit_sel), 16'h2);
    pulse_prog();
    chk("walk_sel_0001", 16'(bus.digit_sel), 16'h1);
    chk("walk_no_load", 16'(bus.load), 16'd0);
    bus.bt_prog = 1'b1;
    tick();
    chk("walk_idle", 16'(bus.state), 16'd0);
    chk("walk_load", 16'(bus.load), 16'd1);
    chk("walk_preset", bus.preset, 16'h0101);
    chk("walk_sel_off", 16'(bus.digit_sel), 16'd0);
    bus.bt_prog = 1'b0;
    tick();
    chk("walk_load_end", 16'(bus.load), 16'd0);
    tick();
    chk("walk_load_end2", 16'(bus.load), 16'd0);
    pulse_prog();
    bus.bt_start = 1'b1;
    bus.bt_inc   = 1'b1;
    tick();
    chk("start_inc_idle", 16'(bus.state), 16'd0);
    chk("start_inc_load", 16'(bus.load), 16'd1);
    chk("start_inc_noinc", bus.preset, 16'h0101);
    bus.bt_start = 1'b0;
    bus.bt_inc   = 1'b0;
    tick();
    chk("start_inc_load_end", 16'(bus.load), 16'd0);
    pulse_start();
    chk("run_again", 16'(bus.state), 16'd1);
    bus.bt_start = 1'b1;
    bus.done     = 1'b1;
    tick();
    chk("done_beats_start", 16'(bus.state), 16'd4);
    bus.bt_start = 1'b0;
    bus.done     = 1'b0;
    tick();
    pulse_start();
    chk("alarm_start_idle", 16'(bus.state), 16'd0);
    pulse_prog();
    pulse_prog();
    repeat (8) pulse_inc();
    pulse_prog();
    repeat (3) pulse_inc();
    pulse_prog();
    repeat (4) pulse_inc();
    chk("edit_0935", bus.preset, 16'h0935);
    rst_n = 1'b0;
    #1;
    chk("midprog_rst_preset", bus.preset, 16'h0100);
    chk("midprog_rst_state", 16'(bus.state), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midprog_rst_noload", 16'(bus.load), 16'd0);
    chk("midprog_rst_sel", 16'(bus.digit_sel), 16'd0);
    bus.done = 1'b1;
    tick();
    tick();
    chk("done_in_idle", 16'(bus.state), 16'd0);
    bus.done = 1'b0;
    pulse_prog();
    pulse_prog();
    pulse_prog();
    pulse_prog();
    chk("rep_sel", 16'(bus.digit_sel), 16'h1);
    bus.bt_inc = 1'b1;
    repeat (20) tick();
    bus.bt_inc = 1'b0;
    tick();
    chk("hold_inc_20", bus.preset, {12'h010, EXP_REP});
    chk("hold_inc_state", 16'(bus.state), 16'd3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
